tabulation_hash_sequencer: RTL
==============================

# tabulation_hash_sequencer

Sequences one shared 4-way tabulation-hash unit (45-bit VPN in, 2-bit hash ID select, 32-bit result registered one cycle later) to produce all `NUM_HASH` bucket indices for a virtual page number. It accepts one VPN per request over a valid/ready handshake and issues hash IDs 0..`NUM_HASH`-1 back-to-back to the hash unit. It collects and truncates the registered results, then presents the full index set on a valid/ready response port. It sits between the TLB-miss/lookup front end and the hash table banks.

## Interface
- `VPN_BITS`, 45, virtual page number width (matches hash unit input).
- `HASH_BITS`, 32, hash unit result width.
- `INDEX_BITS`, 12, bucket index width; 1..`HASH_BITS`.
- `NUM_HASH`, 4, hash functions evaluated per request; 1..4.

- `clk` in 1 — single clock, all state on posedge.
- `reset` in 1 — asynchronous, active-high.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — sequencer can accept; equals (state==IDLE).
- `req_vpn` in `VPN_BITS` — VPN to hash.
- `hash_vpn` out `VPN_BITS` — VPN driven to hash unit (latched copy).
- `hash_id` out 2 — hash function select to hash unit.
- `hash_result` in `HASH_BITS` — hash unit registered output.
- `rsp_valid` out 1 — index set available.
- `rsp_ready` in 1 — consumer accepts.
- `rsp_vpn` out `VPN_BITS` — VPN the indices belong to.
- `rsp_indices` out `NUM_HASH*INDEX_BITS` — index i at `[i*INDEX_BITS +: INDEX_BITS]`.
- `busy` out 1 — state != IDLE.

## Operation
- States: IDLE, ISSUE, LAST, RESP. Counters: `issue_cnt` (2 bits), capture slot = `issue_cnt`-1.
- IDLE: `req_ready`=1. On `req_valid` at an edge, latch `req_vpn` into the VPN register, clear `issue_cnt`, go to ISSUE.
- ISSUE: drive `hash_id`=`issue_cnt`. If `issue_cnt`>0, capture `hash_result[INDEX_BITS-1:0]` into slot `issue_cnt`-1. Increment `issue_cnt`. On `issue_cnt`==`NUM_HASH`-1, go to LAST.
- LAST: capture `hash_result[INDEX_BITS-1:0]` into slot `NUM_HASH`-1. Go to RESP.
- RESP: `rsp_valid`=1. `rsp_vpn` and `rsp_indices` stay stable until `rsp_valid && rsp_ready` at an edge, then go to IDLE.
- `hash_id`=0 in IDLE, LAST and RESP. `hash_vpn` always reflects the latched VPN register.
- No new request is accepted before the response handshake; `req_ready`=0 in ISSUE/LAST/RESP.
- Slots ≥ `NUM_HASH` do not exist. Index truncation is a plain low-bit select with no modulo.
- Reset, asynchronous at any time including mid-ISSUE or in RESP, aborts the request. No response is produced.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `busy`=0, `hash_id`=0, `hash_vpn`=0, `rsp_vpn`=0, `rsp_indices`=0, `issue_cnt`=0.

## Timing
- Hash unit contract: `hash_id`/`hash_vpn` sampled at edge k; `hash_result` is valid in cycle k+1 and captured by the sequencer at edge k+1.
- Request accepted at edge E0. ISSUE occupies E0..E0+`NUM_HASH`, LAST one cycle, and `rsp_valid` rises after edge E0+`NUM_HASH`+1 (5 cycles for `NUM_HASH`=4).
- With `rsp_ready` held high, the minimum request period is `NUM_HASH`+3 cycles (7 for 4): IDLE 1, ISSUE `NUM_HASH`, LAST 1, RESP 1.
- `rsp_ready` back-pressure stalls indefinitely in RESP. Outputs are held and the hash unit is not driven with new IDs.
- Response handshake at edge En puts the block in IDLE after En. A request present then is accepted at En+1.
- All outputs are registered or decoded from state only. No combinational path exists from `rsp_ready` or `req_valid` to any output.

## Test plan
Bench model of the hash unit: `hash_result` <= `hash_vpn[31:0]` ^ {30'b0, `hash_id`}, registered.
- Basic: reset, then `req_vpn`=45'h1234 for one cycle with `rsp_ready`=1 -> `rsp_valid` rises 5 cycles after accept. Indices are 12'h234, 12'h235, 12'h236, 12'h237 and `rsp_vpn`=45'h1234.
- Back-pressure: same request with `rsp_ready`=0 for 10 cycles -> `rsp_valid` held, outputs stable, `req_ready`=0. A second `req_valid` is ignored until the handshake and is then accepted on the next cycle.
- Back-to-back: continuous requests 45'h0, 45'h1FFF_FFFF_FFFF, 45'hABC with `rsp_ready`=1 -> accepts exactly 7 cycles apart. Indices are {000,001,002,003}, {FFF,FFE,FFD,FFC}, {ABC,ABD,ABE,ABF}.
- `hash_id` trace: after accepting 45'h5, `hash_id` sequence is 0,1,2,3 on consecutive cycles, then 0. `hash_vpn`=45'h5 throughout.
- Reset mid-operation: assert `reset` on the 2nd ISSUE cycle -> immediate reset values, no `rsp_valid`. A following request 45'h7 completes normally with {007,006,005,004}.
- `NUM_HASH`=1, `INDEX_BITS`=8: request 45'h1FF -> `rsp_valid` rises 2 cycles after accept with index 8'hFF, and the period is 4 cycles.

Source files
------------

// File: rtl/tabulation_hash_sequencer.sv
`default_nettype none
// ============================================================================
// tabulation_hash_sequencer : runs one shared hash unit NUM_HASH times per VPN
// Revision: 1.0
// ============================================================================
module tabulation_hash_sequencer #(
  parameter int VPN_BITS   = 45,
  parameter int HASH_BITS  = 32,
  parameter int INDEX_BITS = 12,
  parameter int NUM_HASH   = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [VPN_BITS-1:0]              req_vpn,
  output logic [VPN_BITS-1:0]              hash_vpn,
  output logic [1:0]                       hash_id,
  input  logic [HASH_BITS-1:0]             hash_result,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [VPN_BITS-1:0]              rsp_vpn,
  output logic [NUM_HASH*INDEX_BITS-1:0]   rsp_indices,
  output logic                             busy
);

  localparam int         IDX_W   = NUM_HASH * INDEX_BITS;
  localparam logic [1:0] LAST_ID = 2'(NUM_HASH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_LAST  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          issue_cnt_q, issue_cnt_d;
  logic [VPN_BITS-1:0] vpn_q, vpn_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                capture_en;
  logic [1:0]          capture_slot;
  logic                unused_hash_bits;

  // Only the low INDEX_BITS of each hash are kept.
  assign unused_hash_bits = ^hash_result;

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    vpn_d        = vpn_q;
    idx_d        = idx_q;
    capture_en   = 1'b0;
    capture_slot = issue_cnt_q - 2'd1;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          vpn_d       = req_vpn;
          issue_cnt_d = 2'd0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The result arriving now belongs to the id issued one cycle earlier.
        capture_en  = (issue_cnt_q != 2'd0);
        issue_cnt_d = issue_cnt_q + 2'd1;
        if (issue_cnt_q == LAST_ID) begin
          state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        capture_en   = 1'b1;
        capture_slot = LAST_ID;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < NUM_HASH; i++) begin
      if (capture_en && (capture_slot == 2'(i))) begin
        idx_d[i*INDEX_BITS +: INDEX_BITS] = hash_result[INDEX_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= 2'd0;
      vpn_q       <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      vpn_q       <= vpn_d;
      idx_q       <= idx_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign hash_id     = (state_q == ST_ISSUE) ? issue_cnt_q : 2'd0;
  assign hash_vpn    = vpn_q;
  assign rsp_vpn     = vpn_q;
  assign rsp_indices = idx_q;

endmodule
`default_nettype wire
